// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with status, error flags and optional FWFT
// Pointers wrap modulo DEPTH, so any depth >= 2 is supported.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 45,
  parameter int AF_THRESH  = 40,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_param_check
    $error("sync_fifo_param: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_next;
  logic                  wr_acc;
  logic                  rd_acc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_acc     = w_en && !full;
    rd_acc     = r_en && !empty;
    count_next = count;
    if (wr_acc && !rd_acc) begin
      count_next = count + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Flags are registered from count_next so they line up with count.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      count        <= count_next;
      full         <= (count_next == CNT_W'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= CNT_W'(AF_THRESH));
      almost_empty <= (count_next <= CNT_W'(AE_THRESH));
      overflow     <= (w_en && full)  || (overflow  && !err_clr);
      underflow    <= (r_en && empty) || (underflow && !err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !srst) mem[wr_ptr] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = mem[rd_ptr];
  end else begin : g_std
    always_ff @(posedge clk) begin
      if (srst) begin
        data_out <= '0;
      end else if (rd_acc) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized self-checking bench for sync_fifo_param
// u0 uses the default configuration; u1 is a small FWFT instance.
module tb_sync_fifo_param;
  localparam int D0 = 45;
  localparam int D1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst0 = 1'b0, w0 = 1'b0, r0 = 1'b0, clr0 = 1'b0;
  logic [7:0] d0 = '0, dout0;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic [5:0] cnt0;

  logic       srst1 = 1'b0, w1 = 1'b0, r1 = 1'b0, clr1 = 1'b0;
  logic [7:0] d1 = '0, dout1;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0] cnt1;

  sync_fifo_param u0 (
    .clk(clk), .srst(srst0), .w_en(w0), .data_in(d0), .r_en(r0), .data_out(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(unf0), .err_clr(clr0)
  );

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(D1), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) u1 (
    .clk(clk), .srst(srst1), .w_en(w1), .data_in(d1), .r_en(r1), .data_out(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(unf1), .err_clr(clr1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model for u0: a queue plus sticky flags and the last popped word.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0;
  logic [7:0] m_dout = '0;

  task automatic tick0(input logic w, input logic [7:0] d, input logic r,
                       input logic clr, input logic rst);
    logic was_full, was_empty;
    w0 = w; d0 = d; r0 = r; clr0 = clr; srst0 = rst;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    end else begin
      was_full  = (q.size() == D0);
      was_empty = (q.size() == 0);
      if (w && was_full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (r && was_empty) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
      if (r && !was_empty) m_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
    w0 = 1'b0; r0 = 1'b0; clr0 = 1'b0; srst0 = 1'b0;
  endtask

  task automatic tick1(input logic w, input logic [7:0] d, input logic r, input logic rst);
    w1 = w; d1 = d; r1 = r; srst1 = rst;
    @(posedge clk);
    #1;
    w1 = 1'b0; r1 = 1'b0; srst1 = 1'b0;
  endtask

  task automatic test_reset;
    tick0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tests++;
    if (cnt0 !== 6'd0 || empty0 !== 1'b1 || full0 !== 1'b0 || ae0 !== 1'b1 || af0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b ae=%b af=%b, expected 0 1 0 1 0",
               cnt0, empty0, full0, ae0, af0);
    end
    tests++;
    if (ovf0 !== 1'b0 || unf0 !== 1'b0 || dout0 !== 8'h00) begin
      fails++;
      $display("FAIL reset_err_data: ovf=%b unf=%b dout=%h, expected 0 0 00", ovf0, unf0, dout0);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < D0; i++) begin
      tick0(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      tests++;
      if (cnt0 !== 6'(q.size()) || full0 !== (q.size() == D0) ||
          af0 !== (q.size() >= 40) || ae0 !== (q.size() <= 4) || empty0 !== 1'b0) begin
        fails++;
        $display("FAIL fill[%0d]: count=%0d full=%b af=%b ae=%b empty=%b, expected count=%0d",
                 i, cnt0, full0, af0, ae0, empty0, q.size());
      end
    end
    tests++;
    if (cnt0 !== 6'd45 || full0 !== 1'b1) begin
      fails++;
      $display("FAIL fill_full: count=%0d full=%b, expected 45 1", cnt0, full0);
    end
  endtask

  task automatic test_overflow_drain;
    tick0(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    tests++;
    if (ovf0 !== 1'b1 || cnt0 !== 6'd45 || full0 !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set: ovf=%b count=%0d full=%b, expected 1 45 1", ovf0, cnt0, full0);
    end
    for (int i = 0; i < D0; i++) begin
      tick0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tests++;
      if (dout0 !== 8'(i) || cnt0 !== 6'(q.size())) begin
        fails++;
        $display("FAIL drain[%0d]: dout=%h count=%0d, expected %h %0d", i, dout0, cnt0, 8'(i), q.size());
      end
    end
    tests++;
    if (empty0 !== 1'b1 || cnt0 !== 6'd0 || ovf0 !== 1'b1 || unf0 !== 1'b0) begin
      fails++;
      $display("FAIL drain_end: empty=%b count=%0d ovf=%b unf=%b, expected 1 0 1 0",
               empty0, cnt0, ovf0, unf0);
    end
  endtask

  task automatic test_wrap;
    tick0(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick0(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick0(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) != 0, 1'b0, 1'b0);
      tests++;
      if (dout0 !== m_dout || cnt0 !== 6'(q.size()) || ovf0 !== m_ovf || unf0 !== m_unf ||
          empty0 !== (q.size() == 0) || full0 !== (q.size() == D0)) begin
        fails++;
        $display("FAIL wrap[%0d]: dout=%h count=%0d ovf=%b unf=%b, expected %h %0d %b %b",
                 i, dout0, cnt0, ovf0, unf0, m_dout, q.size(), m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_simultaneous;
    tick0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < D0; i++) tick0(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    tick0(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    tests++;
    if (cnt0 !== 6'd44 || ovf0 !== 1'b1 || dout0 !== m_dout) begin
      fails++;
      $display("FAIL simul_full: count=%0d ovf=%b dout=%h, expected 44 1 %h", cnt0, ovf0, dout0, m_dout);
    end
    for (int i = 0; i < 44; i++) tick0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick0(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    tests++;
    if (cnt0 !== 6'd1 || unf0 !== 1'b1 || empty0 !== 1'b0) begin
      fails++;
      $display("FAIL simul_empty: count=%0d unf=%b empty=%b, expected 1 1 0", cnt0, unf0, empty0);
    end
    for (int i = 0; i < 19; i++) tick0(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    tick0(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    tests++;
    if (cnt0 !== 6'd20 || dout0 !== 8'h3C) begin
      fails++;
      $display("FAIL simul_mid: count=%0d dout=%h, expected 20 3c", cnt0, dout0);
    end
  endtask

  task automatic test_reset_mid;
    tick0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) tick0(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    tick0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick0(1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    tests++;
    if (cnt0 !== 6'd0 || empty0 !== 1'b1 || full0 !== 1'b0 || ae0 !== 1'b1 || af0 !== 1'b0 ||
        ovf0 !== 1'b0 || unf0 !== 1'b0 || dout0 !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid: count=%0d empty=%b ae=%b af=%b dout=%h, expected 0 1 1 0 00",
               cnt0, empty0, ae0, af0, dout0);
    end
    tick0(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tests++;
    if (unf0 !== 1'b1) begin
      fails++;
      $display("FAIL clr_vs_set: unf=%b, expected 1", unf0);
    end
    tick0(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tests++;
    if (unf0 !== 1'b0 || ovf0 !== 1'b0) begin
      fails++;
      $display("FAIL err_clr: unf=%b ovf=%b, expected 0 0", unf0, ovf0);
    end
  endtask

  task automatic test_fwft;
    logic [7:0] fq[$];
    logic [7:0] v;
    tick1(1'b0, 8'h00, 1'b0, 1'b1);
    tick1(1'b1, 8'hA5, 1'b0, 1'b0);
    tests++;
    if (empty1 !== 1'b0 || dout1 !== 8'hA5 || cnt1 !== 3'd1) begin
      fails++;
      $display("FAIL fwft_show: empty=%b dout=%h count=%0d, expected 0 a5 1", empty1, dout1, cnt1);
    end
    tick1(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (empty1 !== 1'b1 || cnt1 !== 3'd0) begin
      fails++;
      $display("FAIL fwft_pop: empty=%b count=%0d, expected 1 0", empty1, cnt1);
    end
    for (int i = 0; i < D1; i++) begin
      v = 8'($urandom);
      fq.push_back(v);
      tick1(1'b1, v, 1'b0, 1'b0);
    end
    tests++;
    if (full1 !== 1'b1 || af1 !== 1'b1 || dout1 !== fq[0]) begin
      fails++;
      $display("FAIL fwft_full: full=%b af=%b dout=%h, expected 1 1 %h", full1, af1, dout1, fq[0]);
    end
    for (int i = 0; i < D1; i++) begin
      tests++;
      if (dout1 !== fq[0] || empty1 !== 1'b0) begin
        fails++;
        $display("FAIL fwft_head[%0d]: dout=%h empty=%b, expected %h 0", i, dout1, empty1, fq[0]);
      end
      void'(fq.pop_front());
      tick1(1'b0, 8'h00, 1'b1, 1'b0);
    end
    tests++;
    if (empty1 !== 1'b1 || unf1 !== 1'b0) begin
      fails++;
      $display("FAIL fwft_end: empty=%b unf=%b, expected 1 0", empty1, unf1);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_fwft();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
